imem_loader: RTL and testbench

Boot-time writer for the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes big-endian into 32-bit instructions. It writes each instruction to consecutive word addresses starting at 0 through the instruction memory's write port. It holds the core in reset until the programmed word count has been written.

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader_word_packer.sv | 32 +++
 rtl/imem_loader.sv | 75 +++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM states and byte-packing constants for the instruction-memory loader
package imem_loader_pkg;
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W = 2;
endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: big-endian 4-byte packer; word holds the last completed instruction
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);
    logic [BCNT_W-1:0] byte_cnt;
    logic [23:0]       partial;

    assign word_full = shift_en && byte_cnt == BCNT_W'(BYTES_PER_WORD - 1);

    // shift bytes in MSB first; the fourth byte publishes the full word so it stays stable until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            partial  <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (word_full) word <= {partial, byte_in};
            else partial <= {partial[15:0], byte_in};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into words, writes them from address 0, and holds the core in reset until done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [31:0]       W_Ins,
    output logic              WE,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, next;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] word_cnt;
    logic              accept, last, word_full;

    assign accept     = start && (state == IDLE || state == DONE);
    assign last       = {1'b0, word_cnt} == count - (ADDR_W + 1)'(1);
    assign byte_ready = state == RECV;
    assign WE         = state == WRITE;
    assign busy       = state == RECV || state == WRITE;
    assign done       = state == DONE;
    assign cpu_rst    = state != DONE;

    word_packer packer (
        .clk      (CLK),
        .rst      (RST),
        .clear    (accept),
        .shift_en (byte_ready && byte_valid),
        .byte_in  (byte_in),
        .word     (W_Ins),
        .word_full(word_full)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= next;
    end

    // next state: launch from IDLE/DONE, write after every fourth byte, finish on the last word
    always_comb begin
        next = state;
        if (accept) next = (num_words == '0) ? DONE : RECV;
        else if (state == RECV && word_full) next = WRITE;
        else if (state == WRITE) next = last ? DONE : RECV;
    end

    // clamped word count, word counter and the write address, which holds between writes
    always_ff @(posedge CLK) begin
        if (RST) begin
            count    <= '0;
            word_cnt <= '0;
            W_Addr   <= '0;
        end else begin
            if (accept) begin
                count    <= (num_words > DEPTH) ? DEPTH : num_words;
                word_cnt <= '0;
            end
            if (state == WRITE && !last) word_cnt <= word_cnt + ADDR_W'(1);
            if (word_full) W_Addr <= word_cnt;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stimulus checked every cycle against a transaction-level loader model
module tb_imem_loader;
    localparam int AW = 8;

    logic          CLK = 0, RST = 1, start = 0, byte_valid = 0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_ready, WE, busy, done, cpu_rst;
    logic [AW-1:0] W_Addr;
    logic [31:0]   W_Ins;

    int errors = 0, checks = 0, we_count = 0, last_addr = -1;
    logic [31:0] mem [256];

    bit m_load = 0, m_pend = 0, m_done = 0;
    int m_words = 0, m_target = 0;
    logic [7:0]  m_bytes [$];
    logic [7:0]  m_addr = '0;
    logic [31:0] m_ins = '0;

    always #5 CLK = ~CLK;

    imem_loader #(.ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .num_words(num_words), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .W_Addr(W_Addr), .W_Ins(W_Ins),
        .WE(WE), .busy(busy), .done(done), .cpu_rst(cpu_rst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare outputs to the model, then advance the model with the inputs the next edge will see
    always @(negedge CLK) begin
        chk("WE", 32'(WE), 32'(m_pend));
        chk("byte_ready", 32'(byte_ready), 32'(m_load && !m_pend));
        chk("busy", 32'(busy), 32'(m_load));
        chk("done", 32'(done), 32'(m_done));
        chk("cpu_rst", 32'(cpu_rst), 32'(!m_done));
        chk("W_Addr", 32'(W_Addr), 32'(m_addr));
        chk("W_Ins", W_Ins, m_ins);
        if (WE === 1'b1) begin
            mem[W_Addr] = W_Ins;
            we_count++;
            last_addr = int'(W_Addr);
        end
        if (RST) begin
            m_load = 0; m_pend = 0; m_done = 0; m_words = 0;
            m_bytes.delete(); m_addr = '0; m_ins = '0;
        end else if (m_pend) begin
            m_pend = 0;
            m_words++;
            if (m_words == m_target) begin
                m_load = 0;
                m_done = 1;
            end
        end else if (m_load) begin
            if (byte_valid) begin
                m_bytes.push_back(byte_in);
                if (m_bytes.size() == 4) begin
                    m_ins  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_addr = 8'(m_words);
                    m_pend = 1;
                    m_bytes.delete();
                end
            end
        end else if (start) begin
            if (num_words == '0) m_done = 1;
            else begin
                m_load = 1; m_done = 0; m_words = 0; m_bytes.delete();
                m_target = (int'(num_words) > 256) ? 256 : int'(num_words);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1;
        num_words = (AW + 1)'(n);
        tick();
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input int stall, input bit rnd_start);
        int k;
        bit acc;
        repeat (stall) begin
            byte_valid = 0;
            if (rnd_start) begin
                start = 1'($urandom_range(0, 1));
                num_words = (AW + 1)'($urandom_range(0, 511));
            end
            tick();
        end
        start = 0;
        byte_valid = 1;
        byte_in = b;
        for (k = 0; k < 50; k++) begin
            acc = byte_ready;
            tick();
            if (acc) break;
        end
        byte_valid = 0;
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 100; k++) begin
            if (done) break;
            tick();
        end
        if (k == 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done not seen within 100 cycles");
        end
    endtask

    initial begin
        logic [7:0] two [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        logic [7:0] bb [4];
        int base, n;
        repeat (2) tick();
        RST = 0;
        chk("rst_W_Ins", W_Ins, 32'h0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        byte_valid = 1;
        byte_in = 8'hAA;
        repeat (5) tick();
        byte_valid = 0;
        chk("idle_no_we", 32'(we_count), 32'd0);

        do_start(2);
        foreach (two[i]) send(two[i], 0, 0);
        wait_done();
        chk("two_mem0", mem[0], 32'h12345678);
        chk("two_mem1", mem[1], 32'h9ABCDEF0);
        chk("two_we_count", 32'(we_count), 32'd2);
        chk("two_cpu_rst", 32'(cpu_rst), 32'h0);

        base = we_count;
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            bb[i] = 8'($urandom);
            send(bb[i], 3, 0);
        end
        wait_done();
        chk("stall_mem0", mem[0], {bb[0], bb[1], bb[2], bb[3]});
        chk("stall_we_count", 32'(we_count - base), 32'd1);

        RST = 1;
        tick();
        RST = 0;
        chk("zero_pre_done", 32'(done), 32'h0);
        base = we_count;
        do_start(0);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_no_we", 32'(we_count - base), 32'd0);
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            bb[i] = 8'($urandom);
            if (i == 2) begin
                start = 1;
                num_words = 9'd5;
                tick();
                start = 0;
            end
            send(bb[i], 0, 0);
        end
        wait_done();
        chk("ign_we_count", 32'(we_count - base), 32'd1);
        chk("ign_mem0", mem[0], {bb[0], bb[1], bb[2], bb[3]});

        do_start(1);
        send(8'hDE, 0, 0);
        send(8'hAD, 0, 0);
        RST = 1;
        tick();
        RST = 0;
        chk("midrst_we", 32'(WE), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        base = we_count;
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            bb[i] = 8'(8'h40 + i);
            send(bb[i], 1, 0);
        end
        wait_done();
        chk("midrst_mem0", mem[0], 32'h40414243);
        chk("midrst_we_count", 32'(we_count - base), 32'd1);

        base = we_count;
        do_start(300);
        for (int i = 0; i < 1024; i++) begin
            byte_in = 8'($urandom);
            if (i >= 1020) bb[i - 1020] = byte_in;
            send(byte_in, 0, 0);
        end
        wait_done();
        chk("clamp_we_count", 32'(we_count - base), 32'd256);
        chk("clamp_last_addr", 32'(last_addr), 32'hFF);
        chk("clamp_mem255", mem[255], {bb[0], bb[1], bb[2], bb[3]});
        chk("clamp_done", 32'(done), 32'h1);

        repeat (4) begin
            n = $urandom_range(1, 6);
            base = we_count;
            do_start(n);
            for (int i = 0; i < 4 * n; i++) send(8'($urandom), $urandom_range(0, 2), 1);
            wait_done();
            chk("rand_we_count", 32'(we_count - base), 32'(n));
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
